forward_hazard_unit: RTL and testbench

FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

---
 rtl/pipe_pkg.sv | 13 +
 rtl/md_busy_tracker.sv | 36 +++
 rtl/forward_hazard_unit.sv | 74 +++++++
 tb/tb_forward_hazard_unit.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared select encodings, mult/div state type and default parameters
package pipe_pkg;
   typedef enum logic [1:0] {SEL_RF = 2'b00, SEL_MA = 2'b01, SEL_WB = 2'b10, SEL_IMM = 2'b11} fwd_sel_t;
   typedef enum logic [1:0] {MD_IDLE = 2'b00, MD_BUSY = 2'b01, MD_DONE = 2'b10} md_state_t;
   localparam int DEF_REG_AW = 5;
   localparam int DEF_MD_LAT = 4;
   localparam int DEF_LU_CYC = 2;
   localparam int DEF_CNT_W  = 32;
   // The younger MA result wins over WB when both write the same register
   function automatic fwd_sel_t fwd_pick(input logic ma_hit, input logic wb_hit);
      return ma_hit ? SEL_MA : wb_hit ? SEL_WB : SEL_RF;
   endfunction
endpackage

// File: rtl/md_busy_tracker.sv
// md_busy_tracker: tracks an in-flight mult/div, busy while computing, one-cycle done pulse
module md_busy_tracker
   import pipe_pkg::*;
#(
   parameter int MD_LAT = DEF_MD_LAT
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic busy,
   output logic done
);
   localparam int CW = $clog2(MD_LAT + 1);
   md_state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic launch;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= MD_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end
   // A start in DONE chains straight into the next operation; in BUSY it is ignored
   always_comb begin
      launch  = start && state != MD_BUSY;
      state_n = launch ? MD_BUSY : state == MD_BUSY ? (cnt <= CW'(1) ? MD_DONE : MD_BUSY) : MD_IDLE;
      cnt_n   = launch ? CW'(MD_LAT - 2) : state == MD_BUSY ? cnt - CW'(1) : cnt;
   end
   always_comb begin
      busy = state == MD_BUSY;
      done = state == MD_DONE;
   end
endmodule

// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit: operand forwarding selects, load-use and mult/div stalls, stall counter
module forward_hazard_unit
   import pipe_pkg::*;
#(
   parameter int REG_AW = DEF_REG_AW,
   parameter int MD_LAT = DEF_MD_LAT,
   parameter int LU_CYC = DEF_LU_CYC,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic              id_md_use,
   input  logic [REG_AW-1:0] ex_rs,
   input  logic [REG_AW-1:0] ex_rt,
   input  logic              ex_b_imm,
   input  logic              ex_memwr,
   input  logic [REG_AW-1:0] ex_dst,
   input  logic [REG_AW-1:0] ma_dst,
   input  logic [REG_AW-1:0] wb_dst,
   input  logic              ex_regwr,
   input  logic              ma_regwr,
   input  logic              wb_regwr,
   input  logic              ex_memtoreg,
   input  logic              ma_memtoreg,
   input  logic              ex_md_start,
   input  logic              flush,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [1:0]        fwd_mem,
   output logic              stall,
   output logic              md_busy,
   output logic              md_done,
   output logic [CNT_W-1:0]  stall_cnt
);
   localparam int LW = $clog2(LU_CYC + 1);
   logic ma_ok, wb_ok, lu_hit, stall_lu;
   logic [LW-1:0] lu_cnt;
   fwd_sel_t sel_rt;
   // A load in MA has no data yet, so it is never a forwarding source
   always_comb begin
      ma_ok   = ma_regwr && ma_dst != '0 && !ma_memtoreg;
      wb_ok   = wb_regwr && wb_dst != '0;
      sel_rt  = fwd_pick(ma_ok && ma_dst == ex_rt, wb_ok && wb_dst == ex_rt);
      fwd_a   = fwd_pick(ma_ok && ma_dst == ex_rs, wb_ok && wb_dst == ex_rs);
      fwd_b   = ex_b_imm ? SEL_IMM : sel_rt;
      fwd_mem = ex_memwr ? sel_rt : SEL_RF;
   end
   always_comb begin
      lu_hit   = ex_regwr && ex_memtoreg && ex_dst != '0 &&
                 ((id_use_rs && id_rs == ex_dst) || (id_use_rt && id_rt == ex_dst));
      stall_lu = lu_cnt != '0 || (lu_hit && !flush);
      stall    = stall_lu || (id_md_use && md_busy);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         lu_cnt    <= '0;
         stall_cnt <= '0;
      end else begin
         lu_cnt <= flush ? '0 : lu_cnt != '0 ? lu_cnt - LW'(1) : lu_hit ? LW'(LU_CYC - 1) : '0;
         if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end
   md_busy_tracker #(.MD_LAT(MD_LAT)) u_md (
      .clk   (clk),
      .rst   (rst),
      .start (ex_md_start),
      .busy  (md_busy),
      .done  (md_done)
   );
endmodule

// File: tb/tb_forward_hazard_unit.sv
// tb_forward_hazard_unit: directed and random checks against an age/countdown reference model
module tb_forward_hazard_unit;
   localparam int MD_LAT = 4;
   localparam int LU_CYC = 2;
   localparam int CNT_W  = 4;
   localparam int SAT    = 15;
   logic clk = 0;
   logic rst;
   logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_dst, ma_dst, wb_dst;
   logic id_use_rs, id_use_rt, id_md_use, ex_b_imm, ex_memwr;
   logic ex_regwr, ma_regwr, wb_regwr, ex_memtoreg, ma_memtoreg, ex_md_start, flush;
   logic [1:0] fwd_a, fwd_b, fwd_mem;
   logic stall, md_busy, md_done;
   logic [CNT_W-1:0] stall_cnt;
   int total = 0, bad = 0;
   int m_lu, m_age, m_cnt;
   int n_stall, n_busy, n_done;
   bit e_stall, e_busy, e_done;
   always #5 clk = ~clk;
   forward_hazard_unit #(.REG_AW(5), .MD_LAT(MD_LAT), .LU_CYC(LU_CYC), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
      .id_use_rt(id_use_rt), .id_md_use(id_md_use), .ex_rs(ex_rs), .ex_rt(ex_rt),
      .ex_b_imm(ex_b_imm), .ex_memwr(ex_memwr), .ex_dst(ex_dst), .ma_dst(ma_dst),
      .wb_dst(wb_dst), .ex_regwr(ex_regwr), .ma_regwr(ma_regwr), .wb_regwr(wb_regwr),
      .ex_memtoreg(ex_memtoreg), .ma_memtoreg(ma_memtoreg), .ex_md_start(ex_md_start),
      .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_mem(fwd_mem), .stall(stall),
      .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt));
   task automatic chk(input string tag, input int got, input int exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask
   // Which stage holds the newest usable value of register r
   function automatic int src(input logic [4:0] r);
      if (r != 0 && ma_regwr && !ma_memtoreg && ma_dst == r) return 1;
      if (r != 0 && wb_regwr && wb_dst == r) return 2;
      return 0;
   endfunction
   task automatic clr();
      {id_rs, id_rt, ex_rs, ex_rt, ex_dst, ma_dst, wb_dst} = '0;
      {id_use_rs, id_use_rt, id_md_use, ex_b_imm, ex_memwr} = '0;
      {ex_regwr, ma_regwr, wb_regwr, ex_memtoreg, ma_memtoreg, ex_md_start, flush} = '0;
   endtask
   task automatic chk_fwd();
      chk("fwd_a", fwd_a, src(ex_rs));
      chk("fwd_b", fwd_b, ex_b_imm ? 3 : src(ex_rt));
      chk("fwd_mem", fwd_mem, ex_memwr ? src(ex_rt) : 0);
   endtask
   // One clock: check this cycle's outputs against the model, then advance it
   task automatic cyc();
      bit hit;
      #1;
      hit = ex_regwr && ex_memtoreg && ex_dst != 0 &&
            ((id_use_rs && id_rs == ex_dst) || (id_use_rt && id_rt == ex_dst));
      e_busy  = m_age >= 1 && m_age <= MD_LAT - 2;
      e_done  = m_age == MD_LAT - 1;
      e_stall = m_lu > 0 || (hit && !flush) || (id_md_use && e_busy);
      if (!rst) begin
         chk("stall", stall, e_stall);
         chk("md_busy", md_busy, e_busy);
         chk("md_done", md_done, e_done);
         chk("stall_cnt", stall_cnt, m_cnt);
         chk_fwd();
         n_stall += stall;
         n_busy  += md_busy;
         n_done  += md_done;
      end
      @(posedge clk);
      if (rst) begin
         m_lu = 0; m_age = -1; m_cnt = 0;
      end else begin
         if (e_stall && m_cnt < SAT) m_cnt++;
         m_lu = flush ? 0 : m_lu > 0 ? m_lu - 1 : hit ? LU_CYC - 1 : 0;
         if (ex_md_start && !e_busy) m_age = 1;
         else if (m_age >= 0 && !e_done) m_age++;
         else m_age = -1;
      end
      #1;
   endtask
   initial begin
      m_lu = 0; m_age = -1; m_cnt = 0;
      clr();
      rst = 1;
      @(posedge clk); #1;
      cyc();
      rst = 0;
      #1;
      chk("rst_stall", stall, 0);
      chk("rst_busy", md_busy, 0);
      chk("rst_done", md_done, 0);
      chk("rst_cnt", stall_cnt, 0);
      ex_rs = 3; ma_regwr = 1; ma_dst = 3; wb_regwr = 1; wb_dst = 3;
      #1 chk("ma_over_wb", fwd_a, 1);
      ma_regwr = 0;
      #1 chk("wb_only", fwd_a, 2);
      ma_regwr = 1; ma_dst = 0;
      #1 chk("ma_r0", fwd_a, 2);
      ma_memtoreg = 1; ma_dst = 3;
      #1 chk("ma_load", fwd_a, 2);
      clr();
      ex_b_imm = 1; ex_rt = 7; ma_regwr = 1; ma_dst = 7;
      #1 chk("b_imm", fwd_b, 3);
      ex_memwr = 1; ex_rt = 5; ma_dst = 9; wb_regwr = 1; wb_dst = 5;
      #1 chk("mem_wb", fwd_mem, 2);
      ma_dst = 5;
      #1 chk("mem_ma", fwd_mem, 1);
      cyc();
      clr();
      n_stall = 0;
      ex_regwr = 1; ex_memtoreg = 1; ex_dst = 4; id_rs = 4; id_use_rs = 1;
      cyc();
      clr();
      cyc(); cyc(); cyc();
      chk("lu_len", n_stall, 2);
      chk("lu_cnt", stall_cnt, 2);
      n_stall = 0; n_busy = 0; n_done = 0;
      ex_md_start = 1;
      cyc();
      ex_md_start = 0; id_md_use = 1;
      repeat (5) cyc();
      chk("md_busy_len", n_busy, 2);
      chk("md_done_len", n_done, 1);
      chk("md_stall_len", n_stall, 2);
      clr();
      ex_regwr = 1; ex_memtoreg = 1; ex_dst = 6; id_rt = 6; id_use_rt = 1; flush = 1;
      #1 chk("flush_nostall", stall, 0);
      cyc();
      clr();
      cyc();
      ex_md_start = 1;
      cyc();
      ex_md_start = 0;
      cyc();
      rst = 1;
      cyc();
      rst = 0;
      n_done = 0;
      repeat (4) cyc();
      chk("abort_done", n_done, 0);
      chk("abort_busy", md_busy, 0);
      ex_regwr = 1; ex_memtoreg = 1; ex_dst = 8; id_rs = 8; id_use_rs = 1;
      repeat (19) cyc();
      chk("sat", stall_cnt, 15);
      rst = 1;
      clr();
      cyc();
      rst = 0;
      for (int i = 0; i < 300; i++) begin
         {id_rs, id_rt, ex_rs, ex_rt} = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                                         5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
         {ex_dst, ma_dst, wb_dst} = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                                     5'($urandom_range(0, 3))};
         {id_use_rs, id_use_rt, id_md_use, ex_b_imm, ex_memwr} = 5'($urandom);
         {ex_regwr, ma_regwr, wb_regwr, ex_memtoreg, ma_memtoreg} = 5'($urandom);
         ex_md_start = $urandom_range(0, 3) == 0;
         flush = $urandom_range(0, 5) == 0;
         rst = $urandom_range(0, 40) == 0;
         cyc();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
